key_click_classifier: RTL and testbench



---
 rtl/key_click_classifier.sv | 104 ++++++++++
 tb/tb_key_click_classifier.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/key_click_classifier.sv
// key_click_classifier: turns debounced key edges into single-click,
// double-click and long-press pulses and toggles the two board LEDs.
module key_click_classifier #(
    parameter int LONG_CNT = 50_000_000,
    parameter int GAP_CNT  = 15_000_000,
    parameter int CNT_W    = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_flag,
    input  logic       key_state,
    output logic       single_pulse,
    output logic       double_pulse,
    output logic       long_pulse,
    output logic [1:0] led
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT_GAP,
        PRESS2,
        LONG_HOLD
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CNT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             single_q, single_d;
    logic             double_q, double_d;
    logic             long_q, long_d;
    logic [1:0]       led_q, led_d;

    logic press_edge;
    logic release_edge;

    assign press_edge   = key_flag & ~key_state;
    assign release_edge = key_flag & key_state;

    // State, counter and registered outputs; reset wins over every input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            single_q <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            led_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            single_q <= single_d;
            double_q <= double_d;
            long_q   <= long_d;
            led_q    <= led_d;
        end
    end

    // Next state: the key edge beats a timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (press_edge) state_d = PRESS1;
            end
            PRESS1: begin
                if (release_edge)          state_d = WAIT_GAP;
                else if (cnt_q == LONG_LAST) state_d = LONG_HOLD;
            end
            WAIT_GAP: begin
                if (press_edge)           state_d = PRESS2;
                else if (cnt_q == GAP_LAST) state_d = IDLE;
            end
            PRESS2: begin
                if (release_edge) state_d = IDLE;
            end
            LONG_HOLD: begin
                if (release_edge) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter and event decode; each event is a specific state transition.
    always_comb begin
        cnt_d = '0;
        if (state_d == state_q &&
            (state_q == PRESS1 || state_q == WAIT_GAP)) begin
            cnt_d = cnt_q + 1'b1;
        end
        single_d = (state_q == WAIT_GAP) && (state_d == IDLE);
        double_d = (state_q == PRESS2) && (state_d == IDLE);
        long_d   = (state_q == PRESS1) && (state_d == LONG_HOLD);
        led_d    = led_q ^ {double_d | long_d, single_d | long_d};
    end

    assign single_pulse = single_q;
    assign double_pulse = double_q;
    assign long_pulse   = long_q;
    assign led          = led_q;

endmodule

// File: tb/tb_key_click_classifier.sv
// Directed bench for key_click_classifier with LONG_CNT=20, GAP_CNT=10.
module tb_key_click_classifier;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_flag;
    logic       key_state;
    logic       single_pulse;
    logic       double_pulse;
    logic       long_pulse;
    logic [1:0] led;

    int vectors = 0;
    int miscompares = 0;

    int cyc_n = 0;
    int n_single, n_double, n_long;
    int t_single, t_double, t_long;
    int multi = 0;
    int b2b = 0;
    logic prev_any = 1'b0;
    int p, r, r2;

    key_click_classifier #(
        .LONG_CNT(20),
        .GAP_CNT (10),
        .CNT_W   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_flag    (key_flag),
        .key_state   (key_state),
        .single_pulse(single_pulse),
        .double_pulse(double_pulse),
        .long_pulse  (long_pulse),
        .led         (led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_single = 0; n_double = 0; n_long = 0;
        t_single = -1; t_double = -1; t_long = -1;
    endtask

    // one clock: drive, take the edge, observe at the falling edge
    task automatic cyc(input logic f, input logic s);
        logic any;
        key_flag  = f;
        key_state = s;
        @(posedge clk);
        cyc_n++;
        @(negedge clk);
        if (single_pulse) begin n_single++; t_single = cyc_n; end
        if (double_pulse) begin n_double++; t_double = cyc_n; end
        if (long_pulse)   begin n_long++;   t_long   = cyc_n; end
        if ((32'(single_pulse) + 32'(double_pulse) + 32'(long_pulse)) > 1)
            multi++;
        any = single_pulse | double_pulse | long_pulse;
        if (any && prev_any) b2b++;
        prev_any = any;
        key_flag = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        key_flag  = 1'b0;
        key_state = 1'b1;
        clr();

        // reset with random key activity
        for (int i = 0; i < 5; i++) begin
            cyc(1'($urandom), 1'($urandom));
            chk("rst_pulses", n_single + n_double + n_long, 0);
            chk("rst_led", int'(led), 0);
        end
        rst = 1'b0;
        idle(2);
        chk("post_rst_led", int'(led), 0);

        // release edge in IDLE does nothing
        clr();
        cyc(1'b1, 1'b1);
        idle(15);
        chk("idle_rel_pulses", n_single + n_double + n_long, 0);
        chk("idle_rel_led", int'(led), 0);

        // single click
        clr();
        cyc(1'b1, 1'b0);
        idle(4);
        cyc(1'b1, 1'b1);
        r = cyc_n;
        idle(15);
        chk("single_cnt", n_single, 1);
        chk("single_time", t_single, r + 10);
        chk("single_other", n_double + n_long, 0);
        chk("single_led", int'(led), 1);

        // double click
        clr();
        cyc(1'b1, 1'b0);
        idle(4);
        cyc(1'b1, 1'b1);
        idle(3);
        cyc(1'b1, 1'b0);
        idle(2);
        cyc(1'b1, 1'b1);
        r2 = cyc_n;
        idle(15);
        chk("double_cnt", n_double, 1);
        chk("double_time", t_double, r2);
        chk("double_other", n_single + n_long, 0);
        chk("double_led", int'(led), 3);

        // long press with a duplicate press edge early on
        clr();
        cyc(1'b1, 1'b0);
        p = cyc_n;
        idle(2);
        cyc(1'b1, 1'b0);
        idle(26);
        cyc(1'b1, 1'b1);
        idle(15);
        chk("long_cnt", n_long, 1);
        chk("long_time", t_long, p + 20);
        chk("long_other", n_single + n_double, 0);
        chk("long_led", int'(led), 0);

        // release lands on cnt==19: becomes a single click
        clr();
        cyc(1'b1, 1'b0);
        idle(19);
        cyc(1'b1, 1'b1);
        r = cyc_n;
        idle(15);
        chk("lbound_long", n_long, 0);
        chk("lbound_single", n_single, 1);
        chk("lbound_time", t_single, r + 10);
        chk("lbound_led", int'(led), 1);

        // second press lands on gap cnt==9: double click
        clr();
        cyc(1'b1, 1'b0);
        idle(4);
        cyc(1'b1, 1'b1);
        idle(9);
        cyc(1'b1, 1'b0);
        idle(2);
        cyc(1'b1, 1'b1);
        r2 = cyc_n;
        idle(15);
        chk("gbound_single", n_single, 0);
        chk("gbound_double", n_double, 1);
        chk("gbound_time", t_double, r2);
        chk("gbound_led", int'(led), 3);

        // reset while waiting in the gap
        clr();
        cyc(1'b1, 1'b0);
        idle(4);
        cyc(1'b1, 1'b1);
        idle(3);
        rst = 1'b1;
        idle(2);
        chk("rstgap_led_in", int'(led), 0);
        rst = 1'b0;
        idle(15);
        chk("rstgap_pulses", n_single + n_double + n_long, 0);
        chk("rstgap_led", int'(led), 0);

        chk("one_hot", multi, 0);
        chk("back_to_back", b2b, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
